// File: rtl/sram_1rw1r_wmask_model.sv
// Behavioural 1RW+1R SRAM with per-lane write mask, zero-fill sweep
// after reset and read-first collision flag between the two ports.
module sram_1rw1r_wmask_model #(
  parameter int DATA_WIDTH = 176,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_WMASKS = 8,
  parameter int VERBOSE    = 0
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dvalid0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dvalid1,
  output logic                  busy,
  output logic                  collision
);

  localparam int WM        = DATA_WIDTH / NUM_WMASKS;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]   dout0_q, dout0_d;
  logic [DATA_WIDTH-1:0]   dout1_q, dout1_d;
  logic                    dvalid0_q, dvalid0_d;
  logic                    dvalid1_q, dvalid1_d;
  logic                    coll_q, coll_d;

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   bit_mask;
  logic                    p0_wr;
  logic                    p0_rd;
  logic                    p1_rd;

  // VERBOSE only affects simulation messages, never the outputs.
  logic unused_verbose;
  assign unused_verbose = (VERBOSE != 0);

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      bit_mask[i*WM +: WM] = {WM{wmask0[i]}};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    wr_addr   = cnt_q;
    wr_data   = '0;
    p0_wr     = 1'b0;
    p0_rd     = 1'b0;
    p1_rd     = 1'b0;
    unique case (state_q)
      S_INIT: begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        p0_wr = !csb0 && !web0;
        p0_rd = !csb0 && web0;
        p1_rd = !csb1;
        if (p0_wr) begin
          wr_en   = 1'b1;
          wr_addr = addr0;
          wr_data = (mem_q[addr0] & ~bit_mask) | (din0 & bit_mask);
        end
      end
      default: state_d = S_INIT;
    endcase
    if (rst0) begin
      wr_en = 1'b0;
    end
  end

  // Port 1 samples the array before this edge's write lands: read-first.
  always_comb begin
    dvalid0_d = p0_rd;
    dvalid1_d = p1_rd;
    coll_d    = p1_rd && p0_wr && (addr0 == addr1);
    dout0_d   = p0_rd ? mem_q[addr0] : dout0_q;
    dout1_d   = p1_rd ? mem_q[addr1] : dout1_q;
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      dout0_q   <= '0;
      dout1_q   <= '0;
      dvalid0_q <= 1'b0;
      dvalid1_q <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dout0_q   <= dout0_d;
      dout1_q   <= dout1_d;
      dvalid0_q <= dvalid0_d;
      dvalid1_q <= dvalid1_d;
      coll_q    <= coll_d;
    end
  end

  always_ff @(posedge clk0) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign dout0     = dout0_q;
  assign dout1     = dout1_q;
  assign dvalid0   = dvalid0_q;
  assign dvalid1   = dvalid1_q;
  assign collision = coll_q;
  assign busy      = rst0 || (state_q == S_INIT);

endmodule
